everloop_rx: RTL and testbench

Serial decoder for the Everloop single-wire LED stream, the receive counterpart of the Everloop transmitter. It samples the one-wire data line, classifies each high pulse by its width as a 1 or a 0, and packs the bits MSB first into bytes. Each completed byte is written into the RGB memory as an address/data/write-enable triple. A long low gap marks the end of a frame. The block serves as a loopback checker for the transmitter and as the input stage of a chained LED segment.

---
 rtl/everloop_pkg.sv | 23 ++
 rtl/everloop_sync.sv | 33 +++
 rtl/everloop_rx.sv | 200 ++++++++++++++++++++
 tb/tb_everloop_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/everloop_pkg.sv
// Shared constants for the Everloop single-wire LED link: FSM encodings,
// receiver timing defaults and the transmitter pulse widths they must agree with.
package everloop_pkg;

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  localparam int CNT_W_DEF      = 15;
  localparam int T_GLITCH_DEF   = 8;
  localparam int T_ONE_DEF      = 23;
  localparam int T_HIGH_MAX_DEF = 60;
  localparam int T_RESET_DEF    = 300;
  localparam int MAX_BYTES_DEF  = 141;

  // Transmitter symbol widths in clk cycles; T_ONE sits between the two high widths.
  localparam int TX_T1H = 32;
  localparam int TX_T1L = 30;
  localparam int TX_T0H = 17;
  localparam int TX_T0L = 45;

endpackage

// File: rtl/everloop_sync.sv
// Two-flop synchronizer for the asynchronous data line plus a delayed copy
// used to form one-cycle rise and fall strobes.
module everloop_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic s_q;
  logic prev_q;

  // Synchronizer chain and edge-detect history register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      s_q    <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      s_q    <= meta_q;
      prev_q <= s_q;
    end
  end

  assign s_o    = s_q;
  assign rise_o = s_q & ~prev_q;
  assign fall_o = ~s_q & prev_q;

endmodule

// File: rtl/everloop_rx.sv
// Everloop stream receiver: measures high-pulse widths, decodes bits MSB first
// into bytes, writes them to RGB memory and reports frame boundaries and errors.
module everloop_rx
  import everloop_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int T_GLITCH   = T_GLITCH_DEF,
  parameter int T_ONE      = T_ONE_DEF,
  parameter int T_HIGH_MAX = T_HIGH_MAX_DEF,
  parameter int T_RESET    = T_RESET_DEF,
  parameter int MAX_BYTES  = MAX_BYTES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       everloop_d,
  output logic [7:0] address,
  output logic [7:0] data_RGB,
  output logic       we,
  output logic       frame_done,
  output logic [7:0] frame_len,
  output logic       frame_err,
  output logic       err
);

  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] GLITCH_C   = CNT_W'(T_GLITCH);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(T_ONE);
  localparam logic [CNT_W-1:0] HIGH_MAX_C = CNT_W'(T_HIGH_MAX);
  localparam logic [CNT_W-1:0] GAP_C      = CNT_W'(T_RESET - 1);
  localparam logic [7:0]       MAX_B_C    = 8'(MAX_BYTES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic s_s, rise_s, fall_s;

  everloop_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .d_i   (everloop_d),
    .s_o   (s_s),
    .rise_o(rise_s),
    .fall_o(fall_s)
  );

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_idx_q, byte_idx_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       address_q, address_d;
  logic [7:0]       data_q, data_d;
  logic             we_q, we_d;
  logic             done_q, done_d;
  logic [7:0]       len_q, len_d;
  logic             ferr_q, ferr_d;
  logic             err_q, err_d;
  logic [7:0]       new_byte_s;

  assign new_byte_s = {shift_q[6:0], (cnt_q >= ONE_C)};

  // Next-state: pulse classification, byte assembly and frame bookkeeping
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    ovf_d      = ovf_q;
    address_d  = address_q;
    data_d     = data_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    len_d      = len_q;
    ferr_d     = ferr_q;
    err_d      = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (s_s) begin
          cnt_d = CNT_ZERO;
        end else if (cnt_q >= GAP_C) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_IDLE: begin
        if (rise_s) begin
          cnt_d   = CNT_ONE;
          state_d = ST_HIGH;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      ST_HIGH: begin
        // Over-long width is caught even on the cycle the line finally falls
        if ((cnt_q > HIGH_MAX_C) || (fall_s && (cnt_q < GLITCH_C))) begin
          err_d      = 1'b1;
          cnt_d      = CNT_ZERO;
          bit_cnt_d  = 4'd0;
          shift_d    = 8'd0;
          byte_idx_d = 8'd0;
          ovf_d      = 1'b0;
          state_d    = ST_SYNC;
        end else if (fall_s) begin
          shift_d = new_byte_s;
          cnt_d   = CNT_ONE;
          state_d = ST_LOW;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            if (byte_idx_q < MAX_B_C) begin
              we_d       = 1'b1;
              address_d  = byte_idx_q;
              data_d     = new_byte_s;
              byte_idx_d = byte_idx_q + 8'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_LOW: begin
        if (rise_s) begin
          cnt_d   = CNT_ONE;
          state_d = ST_HIGH;
        end else if (cnt_q >= GAP_C) begin
          if ((byte_idx_q != 8'd0) || (bit_cnt_q != 4'd0)) begin
            done_d = 1'b1;
            len_d  = byte_idx_q;
            ferr_d = (bit_cnt_q != 4'd0) | ovf_q;
          end else begin
            done_d = 1'b0;
          end
          cnt_d      = CNT_ZERO;
          bit_cnt_d  = 4'd0;
          shift_d    = 8'd0;
          byte_idx_d = 8'd0;
          ovf_d      = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = ST_SYNC;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_SYNC;
      cnt_q      <= CNT_ZERO;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      byte_idx_q <= 8'd0;
      ovf_q      <= 1'b0;
      address_q  <= 8'd0;
      data_q     <= 8'd0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      len_q      <= 8'd0;
      ferr_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      ovf_q      <= ovf_d;
      address_q  <= address_d;
      data_q     <= data_d;
      we_q       <= we_d;
      done_q     <= done_d;
      len_q      <= len_d;
      ferr_q     <= ferr_d;
      err_q      <= err_d;
    end
  end

  assign address    = address_q;
  assign data_RGB   = data_q;
  assign we         = we_q;
  assign frame_done = done_q;
  assign frame_len  = len_q;
  assign frame_err  = ferr_q;
  assign err        = err_q;

endmodule

// File: tb/tb_everloop_rx.sv
// Self-checking bench for everloop_rx: directed scenarios plus randomized frames,
// each checked against a pulse-level reference model of the receiver's rules.
module tb_everloop_rx;
  import everloop_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       everloop_d;
  logic [7:0] address, data_RGB, frame_len;
  logic       we, frame_done, frame_err, err;

  always #5 clk = ~clk;

  everloop_rx dut (
    .clk       (clk),
    .rst       (rst),
    .everloop_d(everloop_d),
    .address   (address),
    .data_RGB  (data_RGB),
    .we        (we),
    .frame_done(frame_done),
    .frame_len (frame_len),
    .frame_err (frame_err),
    .err       (err)
  );

  localparam int K_WE = 1, K_DONE = 2, K_ERR = 3;
  typedef struct { int kind; int a; int b; int cyc; } ev_t;
  ev_t exp_q[$];
  ev_t obs_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      if (we)         obs_q.push_back('{K_WE, int'(address), int'(data_RGB), cyc});
      if (frame_done) obs_q.push_back('{K_DONE, int'(frame_len), int'(frame_err), cyc});
      if (err)        obs_q.push_back('{K_ERR, 0, 0, cyc});
    end
  end

  // Reference model operating on whole pulses and low runs
  bit         m_sync;
  int         m_idx, m_bits, m_ovf, m_last_len, m_last_err;
  logic [7:0] m_shift;
  int         low_run;
  bit         line_hi;
  int         last_fall;

  function automatic void m_clear();
    m_idx = 0; m_bits = 0; m_ovf = 0; m_shift = 8'd0;
  endfunction

  function automatic void model_pulse(input int h);
    if (!m_sync) return;
    if (h < 8 || h > 60) begin
      exp_q.push_back('{K_ERR, 0, 0, 0});
      m_sync = 0;
      m_clear();
      return;
    end
    m_shift = {m_shift[6:0], (h >= 23) ? 1'b1 : 1'b0};
    m_bits++;
    if (m_bits == 8) begin
      if (m_idx < 141) begin
        exp_q.push_back('{K_WE, m_idx, int'(m_shift), 0});
        m_idx++;
      end else begin
        m_ovf = 1;
      end
      m_bits = 0;
    end
  endfunction

  function automatic void model_low(input int l);
    if (l < 300) return;
    if (m_sync && (m_idx != 0 || m_bits != 0)) begin
      m_last_len = m_idx;
      m_last_err = (m_bits != 0 || m_ovf != 0) ? 1 : 0;
      exp_q.push_back('{K_DONE, m_last_len, m_last_err, 0});
    end
    m_clear();
    m_sync = 1;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_high(input int h);
    if (low_run > 0) model_low(low_run);
    low_run = 0;
    everloop_d = 1'b1;
    line_hi = 1;
    wait_cyc(h);
    model_pulse(h);
  endtask

  task automatic drive_low(input int l);
    if (line_hi) last_fall = cyc;
    line_hi = 0;
    everloop_d = 1'b0;
    wait_cyc(l);
    low_run += l;
  endtask

  task automatic send_byte(input logic [7:0] b, input int h1, input int l1, input int h0, input int l0);
    for (int i = 7; i >= 0; i--) begin
      drive_high(b[i] ? h1 : h0);
      drive_low(b[i] ? l1 : l0);
    end
  endtask

  task automatic tx_byte(input logic [7:0] b);
    send_byte(b, TX_T1H, TX_T1L, TX_T0H, TX_T0L);
  endtask

  task automatic compare_events(input string tag);
    if (low_run > 0) model_low(low_run);
    low_run = 0;
    chk_eq({tag, ".count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk_eq($sformatf("%s.ev%0d.kind", tag, i), obs_q[i].kind, exp_q[i].kind);
      chk_eq($sformatf("%s.ev%0d.a", tag, i), obs_q[i].a, exp_q[i].a);
      chk_eq($sformatf("%s.ev%0d.b", tag, i), obs_q[i].b, exp_q[i].b);
    end
    chk_eq({tag, ".hold_len"}, frame_len, m_last_len);
    chk_eq({tag, ".hold_err"}, frame_err, m_last_err);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    everloop_d = 1'b0;
    line_hi = 0;
    wait_cyc(n);
    m_sync = 0; m_clear(); m_last_len = 0; m_last_err = 0; low_run = 0;
    chk_eq("rst.address", address, 0);
    chk_eq("rst.data", data_RGB, 0);
    chk_eq("rst.we", we, 0);
    chk_eq("rst.done", frame_done, 0);
    chk_eq("rst.len", frame_len, 0);
    chk_eq("rst.ferr", frame_err, 0);
    chk_eq("rst.err", err, 0);
    rst = 1'b1;
  endtask

  int h, l, nb, r;

  initial begin
    everloop_d = 1'b0;
    rst = 1'b0;
    low_run = 0;
    line_hi = 0;
    last_fall = 0;
    wait_cyc(2);
    do_reset(4);

    // Single byte, with latency of write and frame end from the final fall
    drive_low(400);
    tx_byte(8'hA5);
    drive_low(400);
    if (obs_q.size() >= 2) begin
      chk_eq("t1.lat_we", obs_q[0].cyc - last_fall, 3);
      chk_eq("t1.lat_done", obs_q[1].cyc - last_fall, 302);
    end else begin
      chk_eq("t1.events", obs_q.size(), 2);
    end
    compare_events("t1");

    tx_byte(8'hFF); tx_byte(8'h00); tx_byte(8'h3C);
    drive_low(400);
    compare_events("t2");

    // Glitch mid-byte, trailing bits ignored, then recovery
    send_byte(8'hF0, TX_T1H, TX_T1L, TX_T0H, TX_T0L);
    drive_high(3); drive_low(20);
    drive_high(5); drive_low(30);
    tx_byte(8'h81);
    drive_low(400);
    tx_byte(8'h5A);
    drive_low(400);
    compare_events("t3");

    drive_high(70);
    drive_low(400);
    compare_events("t4");

    for (int i = 0; i < 142; i++) send_byte(8'h55, 24, 5, 8, 5);
    drive_low(400);
    compare_events("t5");

    tx_byte(8'h96);
    send_byte(8'hB0, TX_T1H, TX_T1L, TX_T0H, TX_T0L);
    drive_low(400);
    compare_events("t6");

    // Reset in the middle of a byte, then a frame that needs a fresh sync gap
    drive_high(TX_T1H); drive_low(TX_T1L);
    drive_high(TX_T0H); drive_low(TX_T0L);
    drive_high(TX_T1H); drive_low(TX_T1L);
    drive_high(TX_T1H); drive_low(TX_T1L);
    obs_q.delete(); exp_q.delete();
    do_reset(3);
    drive_low(50);
    tx_byte(8'h77);
    drive_low(400);
    tx_byte(8'hC3);
    drive_low(400);
    compare_events("t7");

    // Random frames with boundary widths and occasional errors
    for (int f = 0; f < 15; f++) begin
      nb = $urandom_range(0, 24);
      for (int k = 0; k < nb; k++) begin
        r = $urandom_range(0, 39);
        case (r)
          0:       h = $urandom_range(2, 7);
          1:       h = $urandom_range(61, 66);
          2:       h = 8;
          3:       h = 22;
          4:       h = 23;
          5:       h = 60;
          default: h = $urandom_range(8, 60);
        endcase
        l = ($urandom_range(0, 29) == 0) ? 299 : $urandom_range(1, 60);
        drive_high(h);
        drive_low(l);
      end
      drive_low($urandom_range(300, 420));
      compare_events($sformatf("rnd%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
